// File: rtl/procesador_param_out_32_bit.sv
// procesador_param_out_32_bit
// Avalon-MM write slave that lets the CPU stage a 32-bit parameter word and
// commit it to the processing chain. The committed word is offered on
// out_port with an out_valid/out_ack handshake. One further commit may wait
// behind the word in flight; any commit beyond that is dropped and flagged.
//
// Handshake: out_valid=1 means out_port holds a word the consumer has not yet
// taken. The word transfers on a clock edge where out_valid=1 and out_ack=1
// (accept). out_port is held stable from the rise of out_valid until accept.
// out_ack is ignored while out_valid=0.
//
// Register map (word offsets):
//   0 STAGE  R/W  word to be committed
//   1 COMMIT W    writedata[0]=1 requests a commit; read {0,pending}
//   2 STATUS R    {0,overrun,pending,out_valid}; write bit2=1 clears overrun
//   3 COUNT  R    completed handshakes, zero-extended; any write clears it
`timescale 1ns/1ps
module procesador_param_out_32_bit #(
    parameter int                      DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0]   RESET_VALUE = '0,
    parameter int                      COUNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [DATA_WIDTH-1:0] writedata,
    output logic [DATA_WIDTH-1:0] readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  out_valid,
    input  logic                  out_ack
);

    localparam logic [1:0] ADDR_STAGE  = 2'd0;
    localparam logic [1:0] ADDR_COMMIT = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_COUNT  = 2'd3;

    logic [DATA_WIDTH-1:0]  stage_q,    stage_d;
    logic [DATA_WIDTH-1:0]  pend_q,     pend_d;
    logic [DATA_WIDTH-1:0]  port_q,     port_d;
    logic [DATA_WIDTH-1:0]  rdata_q,    rdata_d;
    logic [COUNT_WIDTH-1:0] count_q,    count_d;
    logic                   valid_q,    valid_d;
    logic                   pending_q,  pending_d;
    logic                   overrun_q,  overrun_d;

    logic wr;
    logic commit;
    logic accept;

    assign wr     = chipselect & ~write_n;
    assign commit = wr & (address == ADDR_COMMIT) & writedata[0];
    assign accept = valid_q & out_ack;

    // Next-state for the output word, the one-deep queue and the sticky overrun flag
    always_comb begin
        stage_d   = stage_q;
        pend_d    = pend_q;
        port_d    = port_q;
        valid_d   = valid_q;
        pending_d = pending_q;
        overrun_d = overrun_q;

        if (wr && address == ADDR_STAGE) begin
            stage_d = writedata;
        end

        if (wr && address == ADDR_STATUS && writedata[2]) begin
            overrun_d = 1'b0;
        end

        if (accept) begin
            if (pending_q) begin
                // Queued word moves out; a same-cycle commit refills the queue.
                port_d = pend_q;
                if (commit) begin
                    pend_d = stage_q;
                end else begin
                    pending_d = 1'b0;
                end
            end else if (commit) begin
                port_d = stage_q;
            end else begin
                valid_d = 1'b0;
            end
        end else if (commit) begin
            if (!valid_q) begin
                port_d  = stage_q;
                valid_d = 1'b1;
            end else if (!pending_q) begin
                pend_d    = stage_q;
                pending_d = 1'b1;
            end else begin
                // Queue full: request is dropped; set beats a same-cycle clear.
                overrun_d = 1'b1;
            end
        end
    end

    // Handshake counter: a COUNT write beats a same-cycle accept
    always_comb begin
        count_d = count_q;
        if (wr && address == ADDR_COUNT) begin
            count_d = '0;
        end else if (accept) begin
            count_d = count_q + COUNT_WIDTH'(1);
        end
    end

    // Read mux, registered below for one-cycle read latency
    always_comb begin
        rdata_d = '0;
        case (address)
            ADDR_STAGE:  rdata_d = stage_q;
            ADDR_COMMIT: rdata_d[0] = pending_q;
            ADDR_STATUS: rdata_d[2:0] = {overrun_q, pending_q, valid_q};
            ADDR_COUNT:  rdata_d[COUNT_WIDTH-1:0] = count_q;
            default:     rdata_d = '0;
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_q   <= RESET_VALUE;
            pend_q    <= RESET_VALUE;
            port_q    <= RESET_VALUE;
            rdata_q   <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            stage_q   <= stage_d;
            pend_q    <= pend_d;
            port_q    <= port_d;
            rdata_q   <= rdata_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign readdata  = rdata_q;
    assign out_port  = port_q;
    assign out_valid = valid_q;

endmodule
